calc_core: RTL and testbench

//  Calculator datapath/FSM feeding the 7-segment display stage. Consumes decoded key

---
 rtl/calc_core_if.sv | 33 +++
 rtl/calc_core.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_calc_core.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_core_if.sv
// Key-event input and display-value output bundle for the calculator core.
// The keypad decoder / bench drives the master side; calc_core is the slave.
interface calc_core_if #(
    parameter int W = 16
);
    // Key event strobe and code (0-9 digits, A-D operators, E equals, F clear)
    logic         key_valid;
    logic [3:0]   key_code;

    // Value and status toward the display stage
    logic [W-1:0] out;
    logic         busy;
    logic         err;
    logic         done;

    modport master (
        output key_valid,
        output key_code,
        input  out,
        input  busy,
        input  err,
        input  done
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output out,
        output busy,
        output err,
        output done
    );
endinterface

// File: rtl/calc_core.sv
// Calculator core: accumulates decimal operands from key events, evaluates
// + - * in one cycle and / with a W-cycle restoring divider, and presents a
// binary value (0..MAX_VAL) for the BCD/7-segment display stage.
module calc_core #(
    parameter int MAX_VAL = 9999,
    parameter int W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    calc_core_if.slave bus
);

    localparam int W1 = W + 1;
    localparam int W2 = 2 * W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    typedef enum logic [2:0] {
        ST_ENT_A,
        ST_OP,
        ST_ENT_B,
        ST_DIV,
        ST_RESULT,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV
    } op_t;

    // Architectural state
    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    op_t           op_q, op_d;
    logic [W-1:0]  out_q, out_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    // Restoring divider working registers: partial remainder, dividend/quotient
    // shift register (dividend bits leave at the top, quotient bits enter at
    // the bottom) and iteration counter
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Key decode
    logic          is_digit;
    logic          is_op;
    logic          is_eq;
    logic          is_clr;
    op_t           key_op;
    logic [W-1:0]  key_val;

    // Operand entry: value after appending the pressed digit, and whether it still fits
    logic [W2-1:0] digit_wide;
    logic [W2-1:0] a_app;
    logic [W2-1:0] b_app;
    logic          a_fits;
    logic          b_fits;

    // Single-cycle evaluation
    logic [W1-1:0] sum;
    logic [W-1:0]  diff;
    logic [W2-1:0] prod;
    logic          div_zero;
    logic          eval_err;
    logic [W-1:0]  eval_res;

    // One restoring-division step
    logic [W1-1:0] trial;
    logic [W-1:0]  trial_sub;
    logic          trial_fits;
    logic [W-1:0]  rem_step;
    logic [W-1:0]  quo_step;

    // Classify the incoming key code and map operator keys to an op
    always_comb begin
        is_digit = (bus.key_code <= 4'd9);
        is_op    = (bus.key_code >= KEY_ADD) && (bus.key_code <= KEY_DIV);
        is_eq    = (bus.key_code == KEY_EQ);
        is_clr   = (bus.key_code == KEY_CLR);
        key_val  = W'(bus.key_code);
        case (bus.key_code)
            KEY_SUB: key_op = OP_SUB;
            KEY_MUL: key_op = OP_MUL;
            KEY_DIV: key_op = OP_DIV;
            default: key_op = OP_ADD;
        endcase
    end

    // Decimal digit append; done at double width so acc*10+d can never wrap
    assign digit_wide = W2'(bus.key_code);
    assign a_app      = W2'(a_q) * W2'(10) + digit_wide;
    assign b_app      = W2'(b_q) * W2'(10) + digit_wide;
    assign a_fits     = (a_app <= W2'(MAX_VAL));
    assign b_fits     = (b_app <= W2'(MAX_VAL));

    // Evaluate the pending operation and flag results that cannot be displayed
    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = a_q - b_q;
        prod     = W2'(a_q) * W2'(b_q);
        div_zero = (b_q == '0);
        eval_err = 1'b0;
        eval_res = '0;
        case (op_q)
            OP_ADD: begin
                eval_err = (sum > W1'(MAX_VAL));
                eval_res = sum[W-1:0];
            end
            OP_SUB: begin
                eval_err = (b_q > a_q);
                eval_res = diff;
            end
            OP_MUL: begin
                eval_err = (prod > W2'(MAX_VAL));
                eval_res = prod[W-1:0];
            end
            default: begin
                eval_err = div_zero;
                eval_res = '0;
            end
        endcase
    end

    // One quotient bit per cycle, MSB first: shift the next dividend bit into
    // the remainder and subtract the divisor whenever it fits
    always_comb begin
        trial      = {rem_q, quo_q[W-1]};
        trial_fits = (trial >= {1'b0, b_q});
        // Modulo-2^W subtraction is exact here because trial - b < b when it fits
        trial_sub  = trial[W-1:0] - b_q;
        rem_step   = trial_fits ? trial_sub : trial[W-1:0];
        quo_step   = {quo_q[W-2:0], trial_fits};
    end

    // Next-state and register-update logic for the key-driven FSM
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        out_d   = out_q;
        busy_d  = busy_q;
        err_d   = err_q;
        done_d  = 1'b0;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;

        // Divider advances every cycle in DIV; keys other than clear are dropped
        if (state_q == ST_DIV) begin
            rem_d = rem_step;
            quo_d = quo_step;
            if (cnt_q == CW'(W - 1)) begin
                state_d = ST_RESULT;
                a_d     = quo_step;
                out_d   = quo_step;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (bus.key_valid) begin
            if (is_clr) begin
                // Clear wins in every state, including mid-division and ERROR
                state_d = ST_ENT_A;
                a_d     = '0;
                b_d     = '0;
                op_d    = OP_ADD;
                out_d   = '0;
                busy_d  = 1'b0;
                err_d   = 1'b0;
                done_d  = 1'b0;
                rem_d   = '0;
                quo_d   = '0;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_ENT_A: begin
                        if (is_digit) begin
                            if (a_fits) begin
                                a_d   = a_app[W-1:0];
                                out_d = a_app[W-1:0];
                            end
                        end else if (is_op) begin
                            op_d    = key_op;
                            state_d = ST_OP;
                        end
                    end
                    ST_OP: begin
                        if (is_digit) begin
                            b_d     = key_val;
                            out_d   = key_val;
                            state_d = ST_ENT_B;
                        end else if (is_op) begin
                            op_d = key_op;
                        end
                    end
                    ST_ENT_B: begin
                        if (is_digit) begin
                            if (b_fits) begin
                                b_d   = b_app[W-1:0];
                                out_d = b_app[W-1:0];
                            end
                        end else if (is_eq) begin
                            if (eval_err) begin
                                state_d = ST_ERROR;
                                err_d   = 1'b1;
                                out_d   = '0;
                            end else if (op_q == OP_DIV) begin
                                // Dividend loads into the shift register; out holds B until done
                                state_d = ST_DIV;
                                busy_d  = 1'b1;
                                rem_d   = '0;
                                quo_d   = a_q;
                                cnt_d   = '0;
                            end else begin
                                state_d = ST_RESULT;
                                a_d     = eval_res;
                                out_d   = eval_res;
                                done_d  = 1'b1;
                            end
                        end
                    end
                    ST_RESULT: begin
                        if (is_digit) begin
                            // A fresh digit starts a new calculation
                            a_d     = key_val;
                            b_d     = '0;
                            out_d   = key_val;
                            state_d = ST_ENT_A;
                        end else if (is_op) begin
                            // Chain: the result becomes the first operand
                            op_d    = key_op;
                            state_d = ST_OP;
                        end
                    end
                    default: begin
                        // DIV and ERROR ignore everything except clear
                    end
                endcase
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: divider working registers are reset too, so a reset mid-division leaves no stale partial result.
            state_q <= ST_ENT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            out_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_calc_core.sv
// Self-checking bench for calc_core: a key-level reference model predicts
// out/err/busy/done after every key and pushes each expected evaluation
// outcome into a scoreboard that an independent monitor drains on done/err.
module tb_calc_core;

    localparam int W       = 16;
    localparam int MAX_VAL = 9999;

    logic clk = 1'b0;
    logic rst = 1'b0;

    calc_core_if #(.W(W)) bus ();

    calc_core #(.MAX_VAL(MAX_VAL), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit is_err;
        int value;
    } exp_t;

    exp_t sb[$];

    // Reference model: calculator behaviour in terms of what the user sees
    typedef enum {M_FIRST, M_OPSEL, M_SECOND, M_RESULT, M_ERR, M_DIV} mmode_t;
    mmode_t m_mode;
    int     m_a, m_b, m_op, m_out, m_q;
    bit     m_busy, m_err, m_done;

    // Mid-division disturbance: 0 none, 1 non-clear key, 2 clear key, 3 reset pulse
    int inj_mode = 0;
    int inj_at   = 1;
    int inj_key  = 0;

    bit   mon_err_prev = 1'b0;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        if (m_mode == M_DIV && sb.size() > 0) void'(sb.pop_back());
        m_mode = M_FIRST;
        m_a = 0; m_b = 0; m_op = 10; m_out = 0;
        m_busy = 1'b0; m_err = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_eval();
        longint r;
        case (m_op)
            10:      r = m_a + m_b;
            11:      r = m_a - m_b;
            12:      r = longint'(m_a) * longint'(m_b);
            default: r = (m_b == 0) ? -1 : m_a / m_b;
        endcase
        if (r < 0 || r > MAX_VAL) begin
            m_mode = M_ERR; m_err = 1'b1; m_out = 0;
            sb.push_back('{is_err: 1'b1, value: 0});
        end else if (m_op == 13) begin
            m_mode = M_DIV; m_busy = 1'b1; m_q = int'(r);
            sb.push_back('{is_err: 1'b0, value: int'(r)});
        end else begin
            m_mode = M_RESULT; m_a = int'(r); m_out = int'(r); m_done = 1'b1;
            sb.push_back('{is_err: 1'b0, value: int'(r)});
        end
    endtask

    task automatic model_key(input int k);
        bit dig, opk;
        m_done = 1'b0;
        if (k == 15) begin
            model_clear();
            return;
        end
        dig = (k <= 9);
        opk = (k >= 10 && k <= 13);
        case (m_mode)
            M_FIRST: begin
                if (dig && m_a * 10 + k <= MAX_VAL) begin m_a = m_a * 10 + k; m_out = m_a; end
                else if (opk) begin m_op = k; m_mode = M_OPSEL; end
            end
            M_OPSEL: begin
                if (dig) begin m_b = k; m_out = k; m_mode = M_SECOND; end
                else if (opk) m_op = k;
            end
            M_SECOND: begin
                if (dig && m_b * 10 + k <= MAX_VAL) begin m_b = m_b * 10 + k; m_out = m_b; end
                else if (k == 14) model_eval();
            end
            M_RESULT: begin
                if (dig) begin m_a = k; m_b = 0; m_out = k; m_mode = M_FIRST; end
                else if (opk) begin m_op = k; m_mode = M_OPSEL; end
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_out"},  32'(bus.out),  32'(m_out));
        check({tag, "_err"},  32'(bus.err),  32'(m_err));
        check({tag, "_busy"}, 32'(bus.busy), 32'(m_busy));
        check({tag, "_done"}, 32'(bus.done), 32'(m_done));
    endtask

    // Count busy cycles (bounded) and optionally disturb the division midway
    task automatic div_wait();
        int n = 0;
        bit aborted = 1'b0;
        while (bus.busy === 1'b1 && n < 4 * W && !aborted) begin
            n++;
            if (inj_mode != 0 && n == inj_at) begin
                if (inj_mode == 3) begin
                    rst = 1'b0;
                    model_clear();
                end else begin
                    bus.key_valid = 1'b1;
                    bus.key_code  = 4'(inj_key);
                    model_key(inj_key);
                end
                aborted = (inj_mode == 3) || (inj_key == 15);
            end
            @(negedge clk);
            bus.key_valid = 1'b0;
            rst = 1'b1;
        end
        if (aborted) begin
            check_outputs("div_abort");
        end else begin
            check("div_busy_cycles", 32'(n), 32'(W));
            m_mode = M_RESULT; m_a = m_q; m_out = m_q; m_busy = 1'b0; m_done = 1'b1;
            check_outputs("div_done");
        end
    endtask

    task automatic send_key(input int k);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'(k);
        model_key(k);
        @(negedge clk);
        bus.key_valid = 1'b0;
        check_outputs($sformatf("key%0d", k));
        if (m_mode == M_DIV) div_wait();
    endtask

    task automatic idle();
        m_done = 1'b0;
        @(negedge clk);
        check_outputs("idle");
    endtask

    task automatic run_seq(input int seq[$]);
        foreach (seq[i]) send_key(seq[i]);
    endtask

    // Monitor: drain the scoreboard whenever the DUT completes or errors
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                check("sb_has_entry_done", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("sb_done_kind",  32'(mon_e.is_err), 32'd0);
                    check("sb_done_value", 32'(bus.out), 32'(mon_e.value));
                end
            end
            if (bus.err === 1'b1 && !mon_err_prev) begin
                check("sb_has_entry_err", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    check("sb_err_kind", 32'(mon_e.is_err), 32'd1);
                end
                check("sb_err_out",  32'(bus.out),  32'd0);
                check("sb_err_done", 32'(bus.done), 32'd0);
            end
            mon_err_prev = (bus.err === 1'b1);
        end
    end

    // Watchdog so the run always ends
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq[$];
        int k, r;

        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        rst = 1'b0;
        m_mode = M_FIRST;
        model_clear();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst = 1'b1;
        idle();

        // Basic add with a done pulse after E
        seq = '{1, 2, 10, 3, 4, 14}; run_seq(seq);
        check("t1_result", 32'(bus.out), 32'd46);
        idle();

        // Negative subtraction, then clear
        seq = '{15, 5, 0, 11, 7, 0, 14}; run_seq(seq);
        check("t2_err", 32'(bus.err), 32'd1);
        send_key(15);
        check("t2_cleared", 32'(bus.err), 32'd0);

        // Multiply overflow; then digit entry saturating at four digits
        seq = '{9, 9, 9, 9, 12, 2, 14, 15, 1, 2, 3, 4, 5}; run_seq(seq);
        check("t3_digits", 32'(bus.out), 32'd1234);

        // Division with a key dropped mid-divide
        inj_mode = 1; inj_at = W / 2; inj_key = 3;
        seq = '{15, 1, 0, 0, 13, 7, 14}; run_seq(seq);
        check("t4_quot", 32'(bus.out), 32'd14);
        inj_mode = 0;
        idle();

        // Divide by zero, then chaining 8/2=4, 4+3=7
        seq = '{15, 5, 13, 0, 14}; run_seq(seq);
        seq = '{15, 8, 13, 2, 14}; run_seq(seq);
        check("t5_div", 32'(bus.out), 32'd4);
        seq = '{10, 3, 14}; run_seq(seq);
        check("t5_chain", 32'(bus.out), 32'd7);

        // Boundary: exact MAX_VAL sum, zero difference, E ignored in RESULT
        seq = '{15, 9, 9, 9, 9, 10, 0, 14, 14, 15, 5, 11, 5, 14}; run_seq(seq);

        // Reset pulse mid-division, then clear mid-division
        inj_mode = 3; inj_at = 5;
        seq = '{15, 1, 0, 0, 13, 7, 14}; run_seq(seq);
        inj_mode = 2; inj_at = 9; inj_key = 15;
        seq = '{15, 1, 0, 0, 13, 7, 14}; run_seq(seq);
        inj_mode = 0;

        // Randomised key stream
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) idle();
            r = $urandom_range(0, 99);
            if (r < 55)      k = $urandom_range(0, 9);
            else if (r < 75) k = $urandom_range(10, 13);
            else if (r < 92) k = 14;
            else             k = 15;
            if (m_err && $urandom_range(0, 3) == 0) k = 15;
            r = $urandom_range(0, 5);
            inj_mode = (r <= 3) ? r : 0;
            inj_at   = $urandom_range(1, W - 1);
            inj_key  = (inj_mode == 2) ? 15 : $urandom_range(0, 14);
            send_key(k);
        end
        inj_mode = 0;

        repeat (3) idle();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
